// File: rtl/mips_pkg.sv
// Shared types and constants for the MIPS pipeline front end.
package mips_pkg;

  typedef enum logic [1:0] {
    FETCH,
    DROP,
    BUFFERED
  } if_state_t;

  localparam logic [31:0] NOP_WORD = 32'h0;
  localparam logic [31:0] PC_STEP  = 32'd4;

endpackage

// File: rtl/pc_next_sel.sv
// Next-PC priority mux: reset, then redirect, then sequential increment.
module pc_next_sel
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        reset,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  input  logic        advance,
  input  logic [31:0] pc,
  output logic        redirect,
  output logic [31:0] pcNext
);

  assign redirect = branchTaken | jumpTaken;

  always_comb begin
    pcNext = pc;
    if (!reset)
      pcNext = RESET_PC;
    else if (branchTaken)
      pcNext = branchTarget;
    else if (jumpTaken)
      pcNext = jumpTarget;
    else if (advance)
      pcNext = pc + PC_STEP;
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch: owns the PC and the imem request/ready handshake.
module if_stage
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        hazard,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  input  logic        jumpTaken,
  input  logic [31:0] jumpTarget,
  output logic        imemReq,
  output logic [31:0] imemAddr,
  input  logic        imemReady,
  input  logic [31:0] imemData,
  output logic [31:0] pcOutput,
  output logic [31:0] instructionOutput,
  output logic        ifFlushOutput,
  output logic        fetchStall
);

  if_state_t   state;
  logic [31:0] pc;
  logic [31:0] dropAddr;
  logic [31:0] bufInst;
  logic [31:0] bufPc;
  logic [31:0] pcPlus;
  logic [31:0] pcNext;
  logic        redirect;
  logic        outstanding;
  logic        fetchHs;
  logic        deliver;
  logic        fromBuf;

  pc_next_sel #(
    .RESET_PC(RESET_PC)
  ) u_sel (
    .reset       (reset),
    .branchTaken (branchTaken),
    .branchTarget(branchTarget),
    .jumpTaken   (jumpTaken),
    .jumpTarget  (jumpTarget),
    .advance     (fetchHs),
    .pc          (pc),
    .redirect    (redirect),
    .pcNext      (pcNext)
  );

  assign pcPlus      = pc + PC_STEP;
  assign outstanding = (state != BUFFERED);
  assign fetchHs     = (state == FETCH) && imemReady;
  assign fromBuf     = (state == BUFFERED);
  assign deliver     = reset && !redirect && !hazard
                     && (fetchHs || fromBuf);

  assign imemReq  = reset && outstanding;
  assign imemAddr = (state == DROP) ? dropAddr : pc;

  assign ifFlushOutput = reset && redirect;
  assign fetchStall    = !deliver;

  assign instructionOutput = !deliver ? NOP_WORD
                           : fromBuf  ? bufInst
                           : imemData;
  assign pcOutput = !deliver ? 32'h0
                  : fromBuf  ? bufPc
                  : pcPlus;

  always_ff @(posedge clk) begin
    pc <= pcNext;
    if (!reset) begin
      state    <= FETCH;
      dropAddr <= RESET_PC;
      bufInst  <= NOP_WORD;
      bufPc    <= 32'h0;
    end else if (redirect) begin
      bufInst <= NOP_WORD;
      bufPc   <= 32'h0;
      // an unanswered request must be drained before refetching
      if (outstanding && !imemReady) begin
        state    <= DROP;
        dropAddr <= imemAddr;
      end else begin
        state <= FETCH;
      end
    end else begin
      unique case (state)
        FETCH: begin
          if (imemReady && hazard) begin
            bufInst <= imemData;
            bufPc   <= pcPlus;
            state   <= BUFFERED;
          end
        end
        BUFFERED: if (!hazard) state <= FETCH;
        DROP:     if (imemReady) state <= FETCH;
        default:  state <= FETCH;
      endcase
    end
  end

endmodule
